// File: rtl/exu_wb_arb_pkg.sv
// Shared types for the EXU writeback arbiter: request struct, source IDs and sizing constants.
package exu_wb_arb_pkg;

    localparam int XLEN                = 32;
    localparam int REG_FILE_ADDR_WIDTH = 5;
    localparam int TAG_W               = 8;
    localparam int NUM_SRC             = 4;
    localparam int WB_FIFO_DEPTH       = 4;
    localparam int WB_STALL_THRESH     = 2;

    typedef struct packed {
        logic                           valid;
        logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr;
        logic [XLEN-1:0]                data;
        logic [TAG_W-1:0]               instr_tag;
    } wb_req_t;

    // Encoding order doubles as priority: lower value wins arbitration.
    typedef enum logic [1:0] {
        WB_SRC_LSU = 2'd0,
        WB_SRC_DIV = 2'd1,
        WB_SRC_MUL = 2'd2,
        WB_SRC_ALU = 2'd3
    } wb_src_e;

endpackage

// File: rtl/exu_wb_arb_wb_fifo.sv
// Small synchronous circular-buffer FIFO with extra-MSB pointers; a push into a full FIFO
// without a simultaneous pop is dropped so the stored entries are never corrupted.
module wb_fifo
    import exu_wb_arb_pkg::*;
#(
    parameter  int WIDTH = $bits(wb_req_t),
    parameter  int DEPTH = WB_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/exu_wb_arb.sv
// Arbitrates ALU/MUL/DIV/LSU results onto the single register-file write port, buffering
// losers per source and requesting an issue stall before any buffer can overflow.
module exu_wb_arb
    import exu_wb_arb_pkg::*;
#(
    parameter  int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter  int STALL_THRESH = WB_STALL_THRESH,
    localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  wb_req_t                        alu_res,
    input  wb_req_t                        mul_res,
    input  wb_req_t                        div_res,
    input  wb_req_t                        lsu_res,
    output logic [XLEN-1:0]                exu_wb_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0] exu_wb_rd_addr,
    output logic                           exu_wb_rd_wr_en,
    output logic [TAG_W-1:0]               exu_wb_instr_tag,
    output logic                           wb_stall,
    output logic                           wb_overflow
);

    wb_req_t            incoming [NUM_SRC];
    wb_req_t            head     [NUM_SRC];
    wb_req_t            cand     [NUM_SRC];
    logic [CW-1:0]      count    [NUM_SRC];
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] grant;
    wb_req_t            win;
    logic               overflow_evt;

    assign incoming[WB_SRC_LSU] = lsu_res;
    assign incoming[WB_SRC_DIV] = div_res;
    assign incoming[WB_SRC_MUL] = mul_res;
    assign incoming[WB_SRC_ALU] = alu_res;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        wb_fifo #(
            .WIDTH ($bits(wb_req_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (incoming[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (count[g]),
            .head  (head[g])
        );
    end

    // A buffered head always outranks its own source's new request, keeping per-source order.
    always_comb begin
        grant = '0;
        win   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i] = empty[i] ? incoming[i] : head[i];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win.valid && cand[i].valid) begin
                grant[i] = 1'b1;
                win      = cand[i];
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i]  = grant[i] && !empty[i];
            push[i] = incoming[i].valid && !(grant[i] && empty[i]);
        end
    end

    assign overflow_evt = |(push & full & ~pop);

    always_comb begin
        wb_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (count[i] >= CW'(FIFO_DEPTH - STALL_THRESH)) wb_stall = 1'b1;
        end
    end

    // x0 writes still consume the grant and present their tag, but never strobe the regfile.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exu_wb_data      <= '0;
            exu_wb_rd_addr   <= '0;
            exu_wb_rd_wr_en  <= 1'b0;
            exu_wb_instr_tag <= '0;
            wb_overflow      <= 1'b0;
        end else begin
            if (overflow_evt) wb_overflow <= 1'b1;
            exu_wb_rd_wr_en <= win.valid && (win.rd_addr != '0);
            if (win.valid) begin
                exu_wb_data      <= (win.rd_addr == '0) ? '0 : win.data;
                exu_wb_rd_addr   <= win.rd_addr;
                exu_wb_instr_tag <= win.instr_tag;
            end
        end
    end

endmodule

// File: tb/tb_exu_wb_arb.sv
// Directed + randomized bench for exu_wb_arb, checked against a queue-based reference model.
module tb_exu_wb_arb;
    import exu_wb_arb_pkg::*;

    localparam int DEPTH  = WB_FIFO_DEPTH;
    localparam int THRESH = WB_STALL_THRESH;

    logic                           clk = 1'b0;
    logic                           rstn;
    wb_req_t                        alu_res, mul_res, div_res, lsu_res;
    logic [XLEN-1:0]                exu_wb_data;
    logic [REG_FILE_ADDR_WIDTH-1:0] exu_wb_rd_addr;
    logic                           exu_wb_rd_wr_en;
    logic [TAG_W-1:0]               exu_wb_instr_tag;
    logic                           wb_stall;
    logic                           wb_overflow;

    always #5 clk = ~clk;

    exu_wb_arb dut (
        .clk              (clk),
        .rstn             (rstn),
        .alu_res          (alu_res),
        .mul_res          (mul_res),
        .div_res          (div_res),
        .lsu_res          (lsu_res),
        .exu_wb_data      (exu_wb_data),
        .exu_wb_rd_addr   (exu_wb_rd_addr),
        .exu_wb_rd_wr_en  (exu_wb_rd_wr_en),
        .exu_wb_instr_tag (exu_wb_instr_tag),
        .wb_stall         (wb_stall),
        .wb_overflow      (wb_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one queue per source (index = priority, 0 = LSU) plus expected outputs.
    wb_req_t          mq [NUM_SRC][$];
    logic             m_en;
    logic [XLEN-1:0]  m_data;
    logic [4:0]       m_addr;
    logic [TAG_W-1:0] m_tag;
    logic             m_ovf;
    logic [TAG_W-1:0] tag_ctr = 8'd1;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic wb_req_t mk(input logic [4:0] rd, input logic [31:0] d);
        wb_req_t r;
        r.valid     = 1'b1;
        r.rd_addr   = rd;
        r.data      = d;
        r.instr_tag = tag_ctr;
        tag_ctr     = tag_ctr + 8'd1;
        return r;
    endfunction

    function automatic wb_req_t rnd_req(input int pct);
        if (int'($urandom_range(0, 99)) < pct)
            return mk(5'($urandom_range(0, 31)), $urandom);
        return '0;
    endfunction

    function automatic logic model_stall();
        for (int s = 0; s < NUM_SRC; s++)
            if (mq[s].size() >= DEPTH - THRESH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NUM_SRC; s++) mq[s].delete();
        m_en = 1'b0; m_data = '0; m_addr = '0; m_tag = '0; m_ovf = 1'b0;
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_wr_en"}, 32'(exu_wb_rd_wr_en), 32'(m_en));
        chk({pfx, "_data"},  exu_wb_data,          m_data);
        chk({pfx, "_addr"},  32'(exu_wb_rd_addr),  32'(m_addr));
        chk({pfx, "_tag"},   32'(exu_wb_instr_tag), 32'(m_tag));
        chk({pfx, "_stall"}, 32'(wb_stall),        32'(model_stall()));
        chk({pfx, "_ovf"},   32'(wb_overflow),     32'(m_ovf));
    endtask

    // Called #1 after a rising edge: drive requests, advance the model, clock, then compare.
    task automatic cycle(input string pfx, input wb_req_t a, input wb_req_t m,
                         input wb_req_t d, input wb_req_t l);
        wb_req_t in [NUM_SRC];
        wb_req_t e;
        int      w;
        bit      took_in;
        alu_res = a; mul_res = m; div_res = d; lsu_res = l;
        in[0] = l; in[1] = d; in[2] = m; in[3] = a;
        w = -1;
        took_in = 1'b0;
        for (int s = 0; s < NUM_SRC; s++)
            if (w < 0 && (mq[s].size() > 0 || in[s].valid)) w = s;
        if (w >= 0) begin
            if (mq[w].size() > 0) e = mq[w].pop_front();
            else begin e = in[w]; took_in = 1'b1; end
            m_en   = (e.rd_addr != 0);
            m_data = (e.rd_addr == 0) ? '0 : e.data;
            m_addr = e.rd_addr;
            m_tag  = e.instr_tag;
        end else begin
            m_en = 1'b0;
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            if (in[s].valid && !(s == w && took_in)) begin
                if (mq[s].size() < DEPTH) mq[s].push_back(in[s]);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all(pfx);
    endtask

    initial begin
        wb_req_t idle;
        wb_req_t r;
        idle = '0;
        alu_res = '0; mul_res = '0; div_res = '0; lsu_res = '0;
        rstn = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Single ALU result, visible for exactly one cycle.
        cycle("single", mk(5, 32'hDEADBEEF), idle, idle, idle);
        chk("single_en_const",   32'(exu_wb_rd_wr_en), 32'd1);
        chk("single_addr_const", 32'(exu_wb_rd_addr),  32'd5);
        chk("single_data_const", exu_wb_data,          32'hDEADBEEF);
        cycle("single_after", idle, idle, idle, idle);
        chk("single_after_en", 32'(exu_wb_rd_wr_en), 32'd0);

        // Three-way collision drains LSU, MUL, ALU in that order.
        cycle("coll0", mk(1, 32'h11), mk(2, 32'h22), idle, mk(3, 32'h33));
        chk("coll_rd3", 32'(exu_wb_rd_addr), 32'd3);
        cycle("coll1", idle, idle, idle, idle);
        chk("coll_rd2", 32'(exu_wb_rd_addr), 32'd2);
        cycle("coll2", idle, idle, idle, idle);
        chk("coll_rd1", 32'(exu_wb_rd_addr), 32'd1);
        cycle("coll3", idle, idle, idle, idle);

        // MUL results queued behind an LSU burst keep their order.
        for (int k = 0; k < 4; k++)
            cycle("order_burst", idle, (k < 3) ? mk(5'(7 + k), 32'(k)) : idle, idle,
                  mk(5'(12 + k), 32'hA0 + 32'(k)));
        for (int k = 0; k < 3; k++) begin
            cycle("order_drain", idle, idle, idle, idle);
            chk("order_mul_rd", 32'(exu_wb_rd_addr), 32'(7 + k));
        end
        cycle("order_idle", idle, idle, idle, idle);

        // x0 destination consumes the grant without a write strobe.
        r = mk(0, 32'h55);
        cycle("x0", idle, idle, r, idle);
        chk("x0_en",   32'(exu_wb_rd_wr_en),  32'd0);
        chk("x0_data", exu_wb_data,           32'd0);
        chk("x0_tag",  32'(exu_wb_instr_tag), 32'(r.instr_tag));
        cycle("x0_idle", idle, idle, idle, idle);

        // ALU starves behind LSU: stall at occupancy 2, overflow on the fifth push.
        for (int k = 0; k < DEPTH + 1; k++) begin
            cycle("press", mk(5'(20 + k), 32'h100 + 32'(k)), idle, idle, mk(5'd30, 32'(k)));
            chk("press_stall", 32'(wb_stall),    32'(k >= 1));
            chk("press_ovf",   32'(wb_overflow), 32'(k == DEPTH));
        end
        for (int k = 0; k < DEPTH + 1; k++) cycle("press_drain", idle, idle, idle, idle);
        chk("ovf_sticky", 32'(wb_overflow), 32'd1);

        // Randomized traffic at two load levels.
        for (int k = 0; k < 200; k++)
            cycle("rnd_lo", rnd_req(25), rnd_req(25), rnd_req(25), rnd_req(25));
        for (int k = 0; k < 100; k++)
            cycle("rnd_hi", rnd_req(60), rnd_req(50), rnd_req(30), rnd_req(40));
        for (int k = 0; k < 4 * DEPTH + 2; k++)
            cycle("rnd_drain", idle, idle, idle, idle);

        // Asynchronous reset with ALU and MUL buffers non-empty.
        cycle("pre_rst", mk(4, 32'h44), mk(6, 32'h66), idle, mk(8, 32'h88));
        alu_res = '0; mul_res = '0; lsu_res = '0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            cycle("post_rst", idle, idle, idle, idle);
            chk("post_rst_no_wb", 32'(exu_wb_rd_wr_en), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
